set_assoc_branch_target_buffer: RTL and testbench

- Parametrised N-way set-associative BTB with per-entry saturating direction counters.
- Sits between IF (lookup port, same-cycle combinational prediction) and EXEC (update port, registered write).
- Entries allocate only on taken branches/jumps; replacement prefers an invalid way, otherwise a per-set round-robin victim; whole-table flush is supported.

---
 rtl/set_assoc_branch_target_buffer.sv | 164 ++++++++++++++++
 tb/tb_set_assoc_branch_target_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_branch_target_buffer.sv
// N-way set-associative branch target buffer: combinational lookup for IF, registered update from EXEC.
// Define MAVERICKONE_BTB_PERF_EN to build the lookup/hit performance counters; otherwise they read as 0.
module set_assoc_branch_target_buffer #(
    parameter int XLEN      = 64,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] lkp_pc_i,
    output logic            hit_o,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic            upd_mispredict_o,
    output logic [31:0]     lkp_cnt_o,
    output logic [31:0]     hit_cnt_o
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam int TGT_W = XLEN - 2;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [TAG_W-1:0]     tag_q [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]     tag_d [NUM_SETS][NUM_WAYS];
    logic [TGT_W-1:0]     tgt_q [NUM_SETS][NUM_WAYS];
    logic [TGT_W-1:0]     tgt_d [NUM_SETS][NUM_WAYS];
    logic [CNT_WIDTH-1:0] cnt_q [NUM_SETS][NUM_WAYS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
    logic [WAY_W-1:0]     victim_q [NUM_SETS];
    logic [WAY_W-1:0]     victim_d [NUM_SETS];

    logic [IDX_W-1:0]     lkp_idx, upd_idx;
    logic [TAG_W-1:0]     lkp_tag, upd_tag;
    logic                 lkp_hit, upd_hit, upd_pred, evict;
    logic [WAY_W-1:0]     lkp_way, upd_way, alloc_way;
    logic [CNT_WIDTH-1:0] upd_cnt;
    logic                 unused_bits;

    assign lkp_idx = lkp_pc_i[IDX_W+1:2];
    assign lkp_tag = lkp_pc_i[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign unused_bits = ^{lkp_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        lkp_hit   = 1'b0;
        lkp_way   = '0;
        upd_hit   = 1'b0;
        upd_way   = '0;
        alloc_way = victim_q[upd_idx];
        evict     = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lkp_idx][w] && (tag_q[lkp_idx][w] == lkp_tag)) begin
                lkp_hit = 1'b1;
                lkp_way = WAY_W'(w);
            end
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_hit = 1'b1;
                upd_way = WAY_W'(w);
            end
            if (!valid_q[upd_idx][w]) begin
                alloc_way = WAY_W'(w);
                evict     = 1'b0;
            end
        end
    end

    assign hit_o    = lkp_hit;
    assign taken_o  = lkp_hit & cnt_q[lkp_idx][lkp_way][CNT_WIDTH-1];
    assign target_o = taken_o ? {tgt_q[lkp_idx][lkp_way], 2'b00} : lkp_pc_i + XLEN'(4);

    assign upd_cnt  = cnt_q[upd_idx][upd_way];
    assign upd_pred = upd_hit & upd_cnt[CNT_WIDTH-1];
    assign upd_mispredict_o = upd_valid_i &
        ((upd_taken_i != upd_pred) ||
         (upd_taken_i && upd_pred && (tgt_q[upd_idx][upd_way] != upd_target_i[XLEN-1:2])));

    always_comb begin
        tag_d    = tag_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        victim_d = victim_q;
        if (flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_d[s]  = '0;
                victim_d[s] = '0;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    if (upd_cnt != CNT_MAX) cnt_d[upd_idx][upd_way] = upd_cnt + CNT_WIDTH'(1);
                    tgt_d[upd_idx][upd_way] = upd_target_i[XLEN-1:2];
                end else if (upd_cnt != '0) begin
                    cnt_d[upd_idx][upd_way] = upd_cnt - CNT_WIDTH'(1);
                end
            end else if (upd_taken_i) begin
                tag_d[upd_idx][alloc_way]   = upd_tag;
                tgt_d[upd_idx][alloc_way]   = upd_target_i[XLEN-1:2];
                cnt_d[upd_idx][alloc_way]   = CNT_INIT;
                valid_d[upd_idx][alloc_way] = 1'b1;
                // Round-robin only moves past a way it actually displaced.
                if (evict && (NUM_WAYS > 1)) begin
                    victim_d[upd_idx] = (victim_q[upd_idx] == WAY_W'(NUM_WAYS - 1)) ?
                                        '0 : victim_q[upd_idx] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        cnt_q <= cnt_d;
    end

`ifdef MAVERICKONE_BTB_PERF_EN
    logic [31:0] lkp_cnt_q, lkp_cnt_d, hit_cnt_q, hit_cnt_d;

    always_comb begin
        lkp_cnt_d = lkp_cnt_q + 32'd1;
        hit_cnt_d = hit_cnt_q + (hit_o ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            lkp_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            lkp_cnt_q <= lkp_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign lkp_cnt_o = lkp_cnt_q;
    assign hit_cnt_o = hit_cnt_q;
`else
    assign lkp_cnt_o = '0;
    assign hit_cnt_o = '0;
`endif
endmodule

// File: tb/tb_set_assoc_branch_target_buffer.sv
// Bench for set_assoc_branch_target_buffer: directed vector table, reset/perf sequences, randomized run vs. a reference model.
module tb_set_assoc_branch_target_buffer;
    localparam int XLEN = 64;
    localparam int NS   = 16;
    localparam int NW   = 2;
    localparam int CW   = 2;
    localparam int CINIT = 1 << (CW - 1);
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk_i = 1'b0;
    logic            arst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] lkp_pc_i = '0;
    logic            hit_o, taken_o, upd_mispredict_o;
    logic [XLEN-1:0] target_o;
    logic            upd_valid_i = 1'b0;
    logic [XLEN-1:0] upd_pc_i = '0;
    logic            upd_taken_i = 1'b0;
    logic [XLEN-1:0] upd_target_i = '0;
    logic [31:0]     lkp_cnt_o, hit_cnt_o;

    int checks = 0;
    int errors = 0;

    set_assoc_branch_target_buffer #(
        .XLEN(XLEN), .NUM_SETS(NS), .NUM_WAYS(NW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .flush_i(flush_i), .lkp_pc_i(lkp_pc_i),
        .hit_o(hit_o), .taken_o(taken_o), .target_o(target_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_mispredict_o(upd_mispredict_o),
        .lkp_cnt_o(lkp_cnt_o), .hit_cnt_o(hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one record per (set, way), indexed by plain arithmetic on the PC.
    bit          m_valid [NS][NW];
    logic [63:0] m_tag   [NS][NW];
    logic [63:0] m_tgt   [NS][NW];
    int          m_cnt   [NS][NW];
    int          m_vptr  [NS];
    int unsigned m_lkp, m_hit;

    function automatic int m_set(input logic [63:0] pc);
        return int'((pc / 4) % NS);
    endfunction

    function automatic logic [63:0] m_tagof(input logic [63:0] pc);
        return pc / (4 * NS);
    endfunction

    task automatic m_find(input logic [63:0] pc, output bit hit, output int way);
        int s;
        s = m_set(pc);
        hit = 1'b0;
        way = 0;
        for (int w = 0; w < NW; w++) begin
            if (!hit && m_valid[s][w] && m_tag[s][w] == m_tagof(pc)) begin
                hit = 1'b1;
                way = w;
            end
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NS; s++) begin
            m_vptr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic m_step(input bit fl, input bit uv, input logic [63:0] upc,
                          input bit ut, input logic [63:0] utgt);
        bit hit;
        int way, s;
        m_find(upc, hit, way);
        s = m_set(upc);
        if (fl) begin
            m_clear();
        end else if (uv && hit) begin
            if (ut) begin
                m_cnt[s][way] = (m_cnt[s][way] < CMAX) ? m_cnt[s][way] + 1 : CMAX;
                m_tgt[s][way] = utgt & ~64'h3;
            end else begin
                m_cnt[s][way] = (m_cnt[s][way] > 0) ? m_cnt[s][way] - 1 : 0;
            end
        end else if (uv && ut) begin
            way = -1;
            for (int w = 0; w < NW; w++) if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) begin
                way = m_vptr[s];
                m_vptr[s] = (m_vptr[s] + 1) % NW;
            end
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = m_tagof(upc);
            m_tgt[s][way]   = utgt & ~64'h3;
            m_cnt[s][way]   = CINIT;
        end
    endtask

    task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%h expected=%h", tag, what, act, exp);
        end
    endtask

    task automatic drive(input bit fl, input bit uv, input logic [63:0] upc,
                         input bit ut, input logic [63:0] utgt, input logic [63:0] lpc);
        flush_i = fl; upd_valid_i = uv; upd_pc_i = upc;
        upd_taken_i = ut; upd_target_i = utgt; lkp_pc_i = lpc;
    endtask

    // Starts and ends at a negedge; compares combinational outputs against the model, then clocks both.
    task automatic model_cycle(input string tag, input bit fl, input bit uv, input logic [63:0] upc,
                               input bit ut, input logic [63:0] utgt, input logic [63:0] lpc);
        bit eh, et, uh, pred, em;
        int ew, uw;
        logic [63:0] etgt;
        drive(fl, uv, upc, ut, utgt, lpc);
        #1;
        m_find(lpc, eh, ew);
        et   = eh && (m_cnt[m_set(lpc)][ew] >= CINIT);
        etgt = et ? m_tgt[m_set(lpc)][ew] : lpc + 64'd4;
        m_find(upc, uh, uw);
        pred = uh && (m_cnt[m_set(upc)][uw] >= CINIT);
        em   = uv && ((ut != pred) || (ut && pred && m_tgt[m_set(upc)][uw] != (utgt & ~64'h3)));
        chk(tag, "hit", 64'(hit_o), 64'(eh));
        chk(tag, "taken", 64'(taken_o), 64'(et));
        chk(tag, "target", target_o, etgt);
        chk(tag, "mispredict", 64'(upd_mispredict_o), 64'(em));
        @(posedge clk_i);
        m_step(fl, uv, upc, ut, utgt);
        m_lkp++;
        if (eh) m_hit++;
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        arst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h1000);
        m_clear();
        m_lkp = 0;
        m_hit = 0;
        #1;
        chk(tag, "rst hit", 64'(hit_o), 64'd0);
        chk(tag, "rst taken", 64'(taken_o), 64'd0);
        chk(tag, "rst target", target_o, 64'h1004);
        chk(tag, "rst lkp_cnt", 64'(lkp_cnt_o), 64'd0);
        chk(tag, "rst hit_cnt", 64'(hit_cnt_o), 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    typedef struct {
        bit          fl;
        bit          uv;
        logic [63:0] upc;
        bit          ut;
        logic [63:0] utgt;
        logic [63:0] lpc;
        bit          eh;
        bit          et;
        logic [63:0] etgt;
        bit          em;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit fl, bit uv, logic [63:0] upc, bit ut, logic [63:0] utgt,
                               logic [63:0] lpc, bit eh, bit et, logic [63:0] etgt, bit em);
        vec_t r;
        r.fl = fl; r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt;
        r.lpc = lpc; r.eh = eh; r.et = et; r.etgt = etgt; r.em = em;
        return r;
    endfunction

    initial begin
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1000, 0, 0, 'h1004, 0));
        vecs.push_back(v(0, 1, 'h1000,  1, 'h2000,  'h1000, 0, 0, 'h1004, 1));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1000, 1, 1, 'h2000, 0));
        vecs.push_back(v(0, 1, 'h1000,  0, 0,       'h1000, 1, 1, 'h2000, 1));
        vecs.push_back(v(0, 1, 'h1000,  0, 0,       'h1000, 1, 0, 'h1004, 0));
        vecs.push_back(v(0, 1, 'h1000,  0, 0,       'h1000, 1, 0, 'h1004, 0));
        vecs.push_back(v(0, 1, 'h1000,  1, 'h2000,  'h1000, 1, 0, 'h1004, 1));
        vecs.push_back(v(0, 1, 'h1040,  1, 'h3000,  'h1040, 0, 0, 'h1044, 1));
        vecs.push_back(v(0, 1, 'h1080,  1, 'h4000,  'h1040, 1, 1, 'h3000, 1));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1000, 0, 0, 'h1004, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1080, 1, 1, 'h4000, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1040, 1, 1, 'h3000, 0));
        vecs.push_back(v(0, 1, 'h10C0,  1, 'h5000,  'h1080, 1, 1, 'h4000, 1));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1040, 0, 0, 'h1044, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h10C0, 1, 1, 'h5000, 0));
        vecs.push_back(v(1, 1, 'h3000,  1, 'h6000,  'h10C0, 1, 1, 'h5000, 1));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h1040, 0, 0, 'h1044, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h3000, 0, 0, 'h3004, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h10C0, 0, 0, 'h10C4, 0));
        vecs.push_back(v(0, 1, 'h2000,  1, 'h7000,  'h2000, 0, 0, 'h2004, 1));
        vecs.push_back(v(0, 1, 'h2000,  1, 'h7100,  'h2000, 1, 1, 'h7000, 1));
        vecs.push_back(v(0, 1, 'h2000,  1, 'h7100,  'h2000, 1, 1, 'h7100, 0));
        vecs.push_back(v(0, 1, 'h2000,  0, 0,       'h2000, 1, 1, 'h7100, 1));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h2000, 1, 1, 'h7100, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 0));
        vecs.push_back(v(0, 0, 0,       0, 0,       'h2003, 1, 1, 'h7100, 0));

        do_reset("init");
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].fl, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].lpc);
            #1;
            chk(tag, "hit", 64'(hit_o), 64'(vecs[i].eh));
            chk(tag, "taken", 64'(taken_o), 64'(vecs[i].et));
            chk(tag, "target", target_o, vecs[i].etgt);
            chk(tag, "mispredict", 64'(upd_mispredict_o), 64'(vecs[i].em));
            @(posedge clk_i);
            @(negedge clk_i);
        end

        // Reset asserted while a taken update is pending: update must be lost, table cleared.
        drive(0, 1, 'h5000, 1, 'h8000, 'h2000);
        #1;
        chk("midrst", "mispredict", 64'(upd_mispredict_o), 64'd1);
        #1;
        arst_ni = 1'b0;
        #1;
        chk("midrst", "async clear hit", 64'(hit_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        arst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 'h5000);
        #1;
        chk("midrst", "dropped hit", 64'(hit_o), 64'd0);
        chk("midrst", "dropped target", target_o, 64'h5004);
        @(negedge clk_i);

        // Performance counters: 3 lookup cycles after reset, the last two hitting.
        do_reset("perf");
        model_cycle("perf0", 0, 1, 'h1000, 1, 'h2000, 'h1000);
        model_cycle("perf1", 0, 0, 0, 0, 0, 'h1000);
        model_cycle("perf2", 0, 0, 0, 0, 0, 'h1000);
`ifdef MAVERICKONE_BTB_PERF_EN
        chk("perf", "lkp_cnt", 64'(lkp_cnt_o), 64'd3);
        chk("perf", "hit_cnt", 64'(hit_cnt_o), 64'd2);
`else
        chk("perf", "lkp_cnt", 64'(lkp_cnt_o), 64'd0);
        chk("perf", "hit_cnt", 64'(hit_cnt_o), 64'd0);
`endif

        // Randomized traffic over a small tag pool so sets fill, evict and hit often.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] tags [5];
            logic [63:0] upc, lpc, utgt;
            tags[0] = 64'd0; tags[1] = 64'd1; tags[2] = 64'd2; tags[3] = 64'd3;
            tags[4] = 64'h03FF_FFFF_FFFF_FFFF;
            upc  = (tags[$urandom_range(0, 4)] * (4 * NS)) + 64'($urandom_range(0, NS - 1) * 4)
                   + 64'($urandom_range(0, 3));
            lpc  = (tags[$urandom_range(0, 4)] * (4 * NS)) + 64'($urandom_range(0, NS - 1) * 4)
                   + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) lpc = upc;
            utgt = {32'($urandom), 32'($urandom)} & ~64'h3;
            if ($urandom_range(0, 3) == 0 && i > 0) utgt = 64'h4000;
            model_cycle($sformatf("rnd%0d", i), $urandom_range(0, 63) == 0,
                        $urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0, utgt, lpc);
        end
`ifdef MAVERICKONE_BTB_PERF_EN
        chk("rnd", "lkp_cnt", 64'(lkp_cnt_o), 64'(m_lkp));
        chk("rnd", "hit_cnt", 64'(hit_cnt_o), 64'(m_hit));
`else
        chk("rnd", "lkp_cnt", 64'(lkp_cnt_o), 64'd0);
        chk("rnd", "hit_cnt", 64'(hit_cnt_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
